// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: funct3 encodings, response codes
// and the controller state encoding.
package mem_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {
    ErrNone     = 2'b00,
    ErrMisalign = 2'b01,
    ErrRange    = 2'b10,
    ErrIllegal  = 2'b11
  } resp_err_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: merges store data into a read word and
// extracts/extends sub-word load values.
module lsu_align
  import mem_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rword[{off, 3'b000} +: 8];
    half_sel   = off[1] ? rword[31:16] : rword[15:0];
    store_word = rword;
    load_word  = rword;
    // funct3[2] selects zero-extension; funct3[1:0] is the access size
    case (funct3[1:0])
      2'b00: begin
        store_word[{off, 3'b000} +: 8] = wdata[7:0];
        load_word = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        if (off[1]) begin
          store_word[31:16] = wdata[15:0];
        end else begin
          store_word[15:0] = wdata[15:0];
        end
        load_word = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        store_word = wdata;
        load_word  = rword;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: classifies requests, performs sub-word
// stores as read-modify-write and returns extended load data.
module lsu_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDRW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  lsu_state_e state_q, state_d;
  resp_err_e  err_q, err_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;
  logic        accept;
  logic        illegal, misalign, out_of_range;
  logic [31:0] store_word, load_word;

  // Request classification, priority illegal > misaligned > out of range
  always_comb begin
    if (req_we) begin
      illegal = !(req_funct3 inside {Funct3B, Funct3H, Funct3W});
    end else begin
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >> (ADDRW + 2)) != '0;
    if (illegal) begin
      err_d = ErrIllegal;
    end else if (misalign) begin
      err_d = ErrMisalign;
    end else if (out_of_range) begin
      err_d = ErrRange;
    end else begin
      err_d = ErrNone;
    end
  end

  assign accept = (state_q == StIdle) && req_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      err_q    <= ErrNone;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rword_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q    <= err_d;
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == StAccess) begin
        rword_q <= mem_dout;
      end
    end
  end

  lsu_align u_align (
    .rword      (rword_q),
    .wdata      (wdata_q),
    .off        (addr_q[1:0]),
    .funct3     (funct3_q),
    .store_word (store_word),
    .load_word  (load_word)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = ErrNone;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = (err_d != ErrNone) ? StResp : StAccess;
        end
      end
      StAccess: begin
        mem_addr = {addr_q[31:2], 2'b00};
        state_d  = StResp;
      end
      StResp: begin
        mem_addr   = {addr_q[31:2], 2'b00};
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = StIdle;
        if (err_q == ErrNone) begin
          if (we_q) begin
            mem_we  = 1'b1;
            mem_din = store_word;
          end else begin
            resp_rdata = load_word;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Reset kills any in-flight store or response in the same cycle
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = ErrNone;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_din    = '0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, multi-cycle sequences and random
// requests checked against a byte-array memory model.
module tb_lsu_ctrl;

  localparam int unsigned ADDRW = 6;
  localparam int unsigned NBYTES = 4 * (1 << ADDRW);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  lsu_ctrl #(.ADDRW(ADDRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT
  logic [31:0] ram [64];
  assign mem_dout = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_din;

  // Reference memory as plain bytes
  logic [7:0] mref [NBYTES];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int wa);
    return {mref[wa+3], mref[wa+2], mref[wa+1], mref[wa]};
  endfunction

  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [1:0] err,
                          output logic [31:0] rdata, output logic [31:0] din);
    int n;
    int ai;
    logic [31:0] v;
    n = 1 << f3[1:0];
    rdata = '0;
    din = '0;
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) err = 2'd3;
    else if ((a % n) != 0) err = 2'd1;
    else if (a >= NBYTES) err = 2'd2;
    else begin
      err = 2'd0;
      ai = int'(a[7:0]);
      if (we) begin
        for (int i = 0; i < n; i++) mref[ai+i] = wd[8*i +: 8];
        din = model_word(ai & 32'hFC);
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mref[ai+i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rdata = v;
      end
    end
  endtask

  // Issue one request starting at a negedge; returns at the negedge of its response
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [1:0] xerr,
                        input logic [31:0] xrdata, input logic [31:0] xdin);
    int guard;
    int lat;
    int wes;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accepted"}, 32'(guard < 8), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    wes = 0;
    while (!resp_valid && lat < 5) begin
      if (mem_we) wes++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), (xerr != 2'd0) ? 32'd1 : 32'd2);
    check({tag, " early mem_we"}, 32'(wes), 32'd0);
    check({tag, " resp_err"}, 32'(resp_err), 32'(xerr));
    check({tag, " resp_rdata"}, resp_rdata, we ? 32'd0 : xrdata);
    check({tag, " mem_we"}, 32'(mem_we), 32'(we && xerr == 2'd0));
    if (we && xerr == 2'd0) check({tag, " mem_din"}, mem_din, xdin);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  merr;
    logic [31:0] mrd, mdin, a, wd;
    logic [2:0]  f3;
    logic        we;
    int wes, rsp, bad, acc;
    int acc_at [3];
    logic hit;
    logic [31:0] b2b_data [3];

    vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 2'd0, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        2'd0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 3'b010, 32'h10,  32'h11223344, 2'd0, 32'h0,        32'h11223344};
    vecs[3]  = '{1'b1, 3'b000, 32'h12,  32'h000000AA, 2'd0, 32'h0,        32'h11AA3344};
    vecs[4]  = '{1'b0, 3'b010, 32'h10,  32'h0,        2'd0, 32'h11AA3344, 32'h0};
    vecs[5]  = '{1'b0, 3'b000, 32'h12,  32'h0,        2'd0, 32'hFFFFFFAA, 32'h0};
    vecs[6]  = '{1'b0, 3'b100, 32'h12,  32'h0,        2'd0, 32'h000000AA, 32'h0};
    vecs[7]  = '{1'b1, 3'b001, 32'h16,  32'h00008001, 2'd0, 32'h0,        32'h80010000};
    vecs[8]  = '{1'b0, 3'b010, 32'h14,  32'h0,        2'd0, 32'h80010000, 32'h0};
    vecs[9]  = '{1'b0, 3'b001, 32'h16,  32'h0,        2'd0, 32'hFFFF8001, 32'h0};
    vecs[10] = '{1'b0, 3'b101, 32'h16,  32'h0,        2'd0, 32'h00008001, 32'h0};
    vecs[11] = '{1'b0, 3'b010, 32'h11,  32'h0,        2'd1, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 3'b010, 32'h100, 32'h12345678, 2'd2, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 3'b100, 32'h10,  32'h12345678, 2'd3, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 3'b001, 32'h101, 32'h0,        2'd1, 32'h0,        32'h0};

    for (int i = 0; i < 64; i++) ram[i] = '0;
    for (int i = 0; i < int'(NBYTES); i++) mref[i] = '0;

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_din", mem_din, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle req_ready", 32'(req_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      model_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, merr, mrd, mdin);
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].err, vecs[i].rdata, vecs[i].din);
    end

    // Back-to-back stores with req_valid held high
    @(negedge clk);
    b2b_data[0] = 32'hA0A0_0001;
    b2b_data[1] = 32'hB0B0_0002;
    b2b_data[2] = 32'hC0C0_0003;
    for (int k = 0; k < 3; k++) model_op(1'b1, 3'b010, 32'h20 + 32'(4 * k), b2b_data[k], merr, mrd, mdin);
    wes = 0;
    rsp = 0;
    bad = 0;
    acc = 0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h20;
    req_wdata = b2b_data[0];
    for (int c = 0; c < 12; c++) begin
      if (mem_we) wes++;
      if (resp_valid) rsp++;
      if (req_ready && resp_valid) bad++;
      hit = req_ready && req_valid;
      if (hit) begin
        acc_at[acc] = c;
        acc++;
      end
      @(negedge clk);
      if (hit) begin
        if (acc < 3) begin
          req_addr = 32'h20 + 32'(4 * acc);
          req_wdata = b2b_data[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b accepts", 32'(acc), 32'd3);
    check("b2b mem_we pulses", 32'(wes), 32'd3);
    check("b2b responses", 32'(rsp), 32'd3);
    check("b2b ready while busy", 32'(bad), 32'd0);
    if (acc == 3) begin
      check("b2b spacing 1", 32'(acc_at[1] - acc_at[0]), 32'd3);
      check("b2b spacing 2", 32'(acc_at[2] - acc_at[1]), 32'd3);
    end
    for (int k = 0; k < 3; k++) check($sformatf("b2b word %0d", k), ram[8+k], b2b_data[k]);

    // Reset during ACCESS of a byte store
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b000;
    req_addr = 32'h10;
    req_wdata = 32'h0000005A;
    wes = 0;
    while (!req_ready && wes < 8) begin
      @(negedge clk);
      wes++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst access mem_we", 32'(mem_we), 32'd0);
    check("rst access resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst resp_valid", 32'(resp_valid), 32'd0);
    check("post-rst mem_we", 32'(mem_we), 32'd0);
    check("post-rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("post-rst idle resp_valid", 32'(resp_valid), 32'd0);
    check("rst store dropped", ram[4], model_word(16));

    // Random requests against the byte model
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 11) == 0) a = a | (32'h1 << $urandom_range(8, 31));
      wd = $urandom;
      model_op(we, f3, a, wd, merr, mrd, mdin);
      do_req($sformatf("rnd%0d", n), we, f3, a, wd, merr, mrd, mdin);
    end

    @(negedge clk);
    for (int w = 0; w < 64; w++) check($sformatf("final word %0d", w), ram[w], model_word(4 * w));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the core's MEM stage and the word-wide data memory. Accepts one RV32 load/store request at a time and performs sub-word stores by read-modify-write. It extracts and sign/zero-extends sub-word loads and flags misaligned, out-of-range and illegal-size accesses without touching memory. The memory port has combinational read and a synchronous word write indexed by `addr[ADDRW+1:2]`.

## Interface
- `ADDRW`, 6, word-index width of the data memory; valid byte addresses are 0 .. 4*2^ADDRW-1.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 size/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bits used for B/H.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: load result, 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_din` out 32: word to write.
- `mem_dout` in 32: combinational read word.

## Operation
- FSM states IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch we/funct3/addr/wdata and classify.
  - Error: go to RESP.
  - Otherwise: go to ACCESS.
- ACCESS: drive `mem_addr` from the latched address and register `mem_dout` into `rword`. Go to RESP.
- RESP: `resp_valid`=1, then return to IDLE.
  - Successful store: `mem_we`=1 with `mem_din` = merged word.
  - Successful load: `resp_rdata` = extracted value.
- Classification priority is illegal > misaligned > out of range:
  - Illegal: store funct3 not in {000,001,010}, or load funct3 in {011,110,111}.
  - Misaligned: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
  - Out of range: `addr[31:ADDRW+2]`≠0.
- Store merge:
  - B: replace byte lane `addr[1:0]` of `rword` with `wdata[7:0]`.
  - H: replace half `addr[1]` with `wdata[15:0]`.
  - W: `mem_din` = wdata; the read is still performed for uniform latency.
- Load extract: select lane as above; B/H sign-extend, BU/HU zero-extend, W pass-through.
- Errors never assert `mem_we`; `resp_rdata`=0.
- `mem_addr` is driven from the latched address in ACCESS and RESP, and 0 in IDLE.

## Timing
- Reset values: state IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=00, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `rword`=0.
- Latency from the accepting edge: valid access → `resp_valid` 2 cycles later; error → 1 cycle later.
- Throughput: one request per 3 cycles (valid) or 2 cycles (error); `req_ready`=0 in ACCESS and RESP.
- `req_valid` while not ready is ignored, not queued; the requester holds it until accepted.
- `mem_we` is high exactly in the RESP cycle of a valid store. The write lands at that cycle's closing edge, so a load accepted in the next IDLE cycle reads the new data.
- `resp_valid`/`resp_rdata`/`resp_err` are valid only in RESP; outside RESP they are 0.
- `rst` in any state returns to IDLE at that edge. `mem_we` is forced 0 during any cycle with `rst`=1, so an in-flight store is dropped and `resp_valid` is not issued.

## Structure
- Package `mem_pkg`: funct3 constants, `resp_err` codes, FSM state encoding.
- Sub-module `lsu_align` (combinational): inputs `rword`, `wdata`, `addr[1:0]`, `funct3`; outputs merged store word and extended load value. Instantiated once.

## Test plan
- Store word then load word: SW 0x0000_0010 ← 0xDEADBEEF, then LW 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=00, 2-cycle latency each.
- Byte RMW: word 0x10 = 0x11223344; SB addr 0x12 data 0xAA → memory 0x11AA3344; LB 0x12 → 0xFFFFFFAA; LBU 0x12 → 0x000000AA.
- Halfword: SH addr 0x16 data 0x8001 over 0 → word 0x80010000; LH 0x16 → 0xFFFF8001; LHU → 0x00008001.
- Errors:
  - LW 0x11 → `resp_err`=01, 1-cycle latency, no `mem_we`.
  - SW 0x100 with ADDRW=6 → 10.
  - Store funct3=100 → 11.
  - LH 0x101 (misaligned and out of range) → 01.
- Back-to-back: `req_valid` held high across 3 stores; `req_ready` only in IDLE, exactly 3 `mem_we` pulses, no request lost or duplicated.
- Reset mid-store: assert `rst` in ACCESS of SB 0x10 → no `mem_we`, no `resp_valid`, memory unchanged, `req_ready`=1 the cycle after `rst` drops.
